mem_stage_ctrl: RTL and testbench
=================================

MEM_STAGE_CTRL -- requirements
Module: mem_stage_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT, default 15: BUSY cycles without mem_ack before abort.
REQ-002 SHALL have ports, clock and reset first:
- clk  in  1  single clock; all state on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- alu_out_in  in  32  EX/MEM result; memory address for loads/calls.
- reg_dst_in  in  4  destination register.
- pc_plus4_in  in  32  return address; store data for calls.
- reg_wr_in, wb_sel_in, call_in, high_in, low_in  in  1 each  EX/MEM control; wb_sel_in=1 means load.
- stall_out  out  1  freezes EX/MEM and upstream stages.
- mem_req, mem_we  out  1 each  data-memory request, write enable.
- mem_addr, mem_wdata  out  32 each  request address, write data.
- mem_rdata  in  32  read data, valid with mem_ack.
- mem_ack  in  1  one-cycle completion strobe.
- wb_data  out  32  writeback value.
- wb_reg_dst  out  4  writeback register.
- wb_reg_wr, wb_high, wb_low  out  1 each  writeback enables.
- mem_err  out  1  one-cycle timeout pulse.

Function
REQ-003 SHALL classify the incoming op as a memory op when wb_sel_in or call_in is 1.
REQ-004 SHALL implement states IDLE, BUSY, DONE.
REQ-005 IDLE, non-memory op: at each edge, WB outputs load from the inputs (latency 1); wb_data=alu_out_in; stall_out=0.
REQ-006 IDLE, memory op: stall_out=1 combinationally; at the edge, inputs are captured into hold registers, WB enables load 0 (bubble), state goes to BUSY.
REQ-007 BUSY: mem_req=1; mem_addr=held alu_out; mem_we=held call; mem_wdata=held pc_plus4 when call, else 0; stall_out=1; WB enables held at 0.
REQ-008 BUSY, mem_ack sampled high: mem_rdata latches; state goes to DONE.
REQ-009 BUSY, no ack for TIMEOUT consecutive cycles: mem_err pulses 1 for the next cycle; state goes to DONE; the op's writeback is suppressed.
REQ-010 Ack in the same cycle the counter reaches TIMEOUT SHALL count as success; no mem_err.
REQ-011 DONE: stall_out=0; mem_req=0; at the edge, WB outputs load from hold registers; state goes to IDLE.
  - wb_data = latched rdata for loads, held alu_out otherwise.
  - wb_reg_wr = held reg_wr AND NOT timeout; same rule for wb_high and wb_low.
REQ-012 Memory-op latency SHALL be: issue edge, then BUSY cycles through the ack edge, then one DONE edge to WB; minimum 3 edges when ack arrives in the first BUSY cycle.
REQ-013 mem_ack outside BUSY SHALL be ignored.
REQ-014 The timeout counter SHALL clear on entry to BUSY; its width is $clog2(TIMEOUT+1); it SHALL NOT wrap.
REQ-015 mem_req SHALL stay asserted and all request outputs SHALL stay stable from BUSY entry until the ack or timeout.
REQ-016 Load with call_in also set SHALL act as a store: call wins; wb_data=held alu_out.

Reset
REQ-017 rst_n low SHALL immediately force:
  - state=IDLE, counter=0;
  - mem_req, mem_we, mem_addr, mem_wdata, mem_err = 0;
  - wb_data, wb_reg_dst, wb_reg_wr, wb_high, wb_low = 0;
  - all hold registers = 0.
REQ-018 Reset during BUSY SHALL abandon the transaction; no writeback and no mem_err after release.
REQ-019 After reset release, stall_out SHALL depend only on the inputs per REQ-005/006.

Structure
REQ-020 State enum (IDLE, BUSY, DONE) and TIMEOUT default SHALL live in shared package cpu_pkg.
REQ-021 The WB output register SHALL be sub-module mem_wb_reg, async active-low reset, with a load-bubble input; the FSM stays in mem_stage_ctrl.

Verification
REQ-022 Bench SHALL cover these directed scenarios:
- ALU op, alu_out_in=0x1234, reg_dst_in=5, reg_wr_in=1 -> next edge: wb_data=0x1234, wb_reg_dst=5, wb_reg_wr=1, stall_out=0.
- Load at addr 0x40, ack with rdata=0xDEADBEEF after 2 BUSY cycles -> mem_req high 2 cycles with mem_addr=0x40, mem_we=0; stall_out high 3 cycles; wb_data=0xDEADBEEF one edge after DONE.
- Call, alu_out_in=0x100, pc_plus4_in=0x2C -> mem_we=1, mem_addr=0x100, mem_wdata=0x2C; after ack, wb_data=0x100.
- Load, no ack, TIMEOUT=15 -> mem_req high exactly 15 cycles; mem_err one pulse; wb_reg_wr=0; stall_out released.
- Ack in the 15th BUSY cycle -> success, mem_err=0; stray ack in IDLE -> no effect.
- rst_n low mid-BUSY -> all outputs 0 immediately; after release, an ALU op completes normally.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared types for the CPU pipeline: MEM-stage FSM states,
// EX/MEM and MEM/WB bundles, and the memory timeout default.
package cpu_pkg;

    localparam int TIMEOUT_DEF = 15;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } mem_state_e;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] pc4;
        logic [3:0]  dst;
        logic        wr;
        logic        sel;
        logic        call;
        logic        high;
        logic        low;
    } ex_mem_t;

    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  dst;
        logic        wr;
        logic        high;
        logic        low;
    } mem_wb_t;

    function automatic logic is_mem_op(logic sel, logic call);
        return sel | call;
    endfunction

endpackage

// File: rtl/mem_wb_reg.sv
// MEM/WB output register; a bubble clears only the write
// enables so the data fields keep their last value.
module mem_wb_reg
    import cpu_pkg::*;
(
    input  logic    clk,
    input  logic    rst_n,
    input  logic    load,
    input  logic    bubble,
    input  mem_wb_t d,
    output mem_wb_t q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (bubble) begin
            q.wr   <= 1'b0;
            q.high <= 1'b0;
            q.low  <= 1'b0;
        end else if (load) begin
            q <= d;
        end
    end

endmodule

// File: rtl/mem_stage_ctrl.sv
// MEM stage controller: passes ALU results to WB and runs a
// stalling load/call handshake with a bounded wait for mem_ack.
module mem_stage_ctrl
    import cpu_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] alu_out_in,
    input  logic [3:0]  reg_dst_in,
    input  logic [31:0] pc_plus4_in,
    input  logic        reg_wr_in,
    input  logic        wb_sel_in,
    input  logic        call_in,
    input  logic        high_in,
    input  logic        low_in,
    output logic        stall_out,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack,
    output logic [31:0] wb_data,
    output logic [3:0]  wb_reg_dst,
    output logic        wb_reg_wr,
    output logic        wb_high,
    output logic        wb_low,
    output logic        mem_err
);

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    mem_state_e  state;
    mem_state_e  state_nxt;
    ex_mem_t     hold;
    logic [31:0] rdata_q;
    logic [CW-1:0] cnt;
    logic        to_q;
    logic        err_q;

    logic        in_mem;
    logic        busy;
    logic        busy_to;
    logic        wb_load;
    logic        wb_bubble;
    mem_wb_t     wb_d;
    mem_wb_t     wb_q;

    assign in_mem = is_mem_op(wb_sel_in, call_in);
    assign busy   = (state == BUSY);

    always_comb begin
        state_nxt = state;
        stall_out = 1'b0;
        wb_load   = 1'b0;
        wb_bubble = 1'b0;
        wb_d      = '0;
        busy_to   = 1'b0;
        unique case (state)
            IDLE: begin
                if (in_mem) begin
                    stall_out = 1'b1;
                    wb_bubble = 1'b1;
                    state_nxt = BUSY;
                end else begin
                    wb_load   = 1'b1;
                    wb_d.data = alu_out_in;
                    wb_d.dst  = reg_dst_in;
                    wb_d.wr   = reg_wr_in;
                    wb_d.high = high_in;
                    wb_d.low  = low_in;
                end
            end
            BUSY: begin
                stall_out = 1'b1;
                wb_bubble = 1'b1;
                if (mem_ack) begin
                    state_nxt = DONE;
                end else if (cnt == CNT_LAST) begin
                    busy_to   = 1'b1;
                    state_nxt = DONE;
                end
            end
            DONE: begin
                wb_load   = 1'b1;
                // a call is a store even when wb_sel is also set
                wb_d.data = (hold.sel && !hold.call)
                          ? rdata_q : hold.addr;
                wb_d.dst  = hold.dst;
                wb_d.wr   = hold.wr & ~to_q;
                wb_d.high = hold.high & ~to_q;
                wb_d.low  = hold.low & ~to_q;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            hold    <= '0;
            rdata_q <= '0;
            cnt     <= '0;
            to_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state <= state_nxt;
            err_q <= busy_to;
            if (state == IDLE && in_mem) begin
                hold.addr <= alu_out_in;
                hold.pc4  <= pc_plus4_in;
                hold.dst  <= reg_dst_in;
                hold.wr   <= reg_wr_in;
                hold.sel  <= wb_sel_in;
                hold.call <= call_in;
                hold.high <= high_in;
                hold.low  <= low_in;
                cnt       <= '0;
                to_q      <= 1'b0;
            end
            if (busy) begin
                if (mem_ack) begin
                    rdata_q <= mem_rdata;
                end else if (cnt != CNT_MAX) begin
                    cnt <= cnt + 1'b1;
                end
                if (busy_to) begin
                    to_q <= 1'b1;
                end
            end
        end
    end

    assign mem_req   = busy;
    assign mem_we    = busy & hold.call;
    assign mem_addr  = busy ? hold.addr : '0;
    assign mem_wdata = (busy && hold.call) ? hold.pc4 : '0;
    assign mem_err   = err_q;

    mem_wb_reg u_wb (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (wb_load),
        .bubble (wb_bubble),
        .d      (wb_d),
        .q      (wb_q)
    );

    assign wb_data    = wb_q.data;
    assign wb_reg_dst = wb_q.dst;
    assign wb_reg_wr  = wb_q.wr;
    assign wb_high    = wb_q.high;
    assign wb_low     = wb_q.low;

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Self-checking bench for mem_stage_ctrl: vector table,
// directed memory sequences and randomized op streams.
module tb_mem_stage_ctrl;

    localparam int TO = 15;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] alu_out_in;
    logic [3:0]  reg_dst_in;
    logic [31:0] pc_plus4_in;
    logic        reg_wr_in;
    logic        wb_sel_in;
    logic        call_in;
    logic        high_in;
    logic        low_in;
    logic        stall_out;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;
    logic [31:0] wb_data;
    logic [3:0]  wb_reg_dst;
    logic        wb_reg_wr;
    logic        wb_high;
    logic        wb_low;
    logic        mem_err;

    int n_tot  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    mem_stage_ctrl #(.TIMEOUT(TO)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .alu_out_in  (alu_out_in),
        .reg_dst_in  (reg_dst_in),
        .pc_plus4_in (pc_plus4_in),
        .reg_wr_in   (reg_wr_in),
        .wb_sel_in   (wb_sel_in),
        .call_in     (call_in),
        .high_in     (high_in),
        .low_in      (low_in),
        .stall_out   (stall_out),
        .mem_req     (mem_req),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata),
        .mem_ack     (mem_ack),
        .wb_data     (wb_data),
        .wb_reg_dst  (wb_reg_dst),
        .wb_reg_wr   (wb_reg_wr),
        .wb_high     (wb_high),
        .wb_low      (wb_low),
        .mem_err     (mem_err)
    );

    typedef struct {
        logic [31:0] alu;
        logic [3:0]  dst;
        logic        wr;
        logic        hi;
        logic        lo;
        logic [31:0] e_data;
        logic [3:0]  e_dst;
        logic        e_wr;
        logic        e_hi;
        logic        e_lo;
    } vec_t;

    vec_t tbl[5];

    task automatic chk(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h",
                      nm, act, exp);
    endtask

    task automatic drive(input logic [31:0] alu,
                         input logic [31:0] pc4,
                         input logic [3:0]  dst,
                         input logic wr, sel, call,
                         input logic hi, lo);
        alu_out_in  = alu;
        pc_plus4_in = pc4;
        reg_dst_in  = dst;
        reg_wr_in   = wr;
        wb_sel_in   = sel;
        call_in     = call;
        high_in     = hi;
        low_in      = lo;
    endtask

    // Called at a negedge with the DUT idle; returns at a
    // negedge one edge later with the result in WB.
    task automatic alu_op(input logic [31:0] alu,
                          input logic [3:0]  dst,
                          input logic wr, hi, lo,
                          input logic stray);
        drive(alu, $urandom, dst, wr, 1'b0, 1'b0, hi, lo);
        mem_ack   = stray;
        mem_rdata = $urandom;
        #1;
        chk("alu_stall", stall_out, 0);
        chk("alu_req", mem_req, 0);
        @(negedge clk);
        mem_ack = 1'b0;
        chk("alu_wb_data", wb_data, alu);
        chk("alu_wb_dst", wb_reg_dst, dst);
        chk("alu_wb_wr", wb_reg_wr, wr);
        chk("alu_wb_hi", wb_high, hi);
        chk("alu_wb_lo", wb_low, lo);
        chk("alu_err", mem_err, 0);
    endtask

    // d = BUSY cycle in which ack arrives; d > TO never acks.
    task automatic mem_op(input logic [31:0] addr,
                          input logic [31:0] pc4,
                          input logic [3:0]  dst,
                          input logic wr, sel, call,
                          input logic hi, lo,
                          input int d,
                          input logic [31:0] rdata,
                          input logic pre_ack);
        int   blen;
        logic to;
        blen = (d <= TO) ? d : TO;
        to   = (d > TO);
        drive(addr, pc4, dst, wr, sel, call, hi, lo);
        mem_ack   = pre_ack;
        mem_rdata = $urandom;
        #1;
        chk("issue_stall", stall_out, 1);
        chk("issue_req", mem_req, 0);
        @(negedge clk);
        for (int k = 1; k <= blen; k++) begin
            chk("busy_req", mem_req, 1);
            chk("busy_addr", mem_addr, addr);
            chk("busy_we", mem_we, call);
            chk("busy_wdata", mem_wdata, call ? pc4 : 0);
            chk("busy_stall", stall_out, 1);
            chk("busy_wb_wr", wb_reg_wr, 0);
            chk("busy_err", mem_err, 0);
            mem_ack   = (k == d);
            mem_rdata = (k == d) ? rdata : $urandom;
            @(negedge clk);
        end
        mem_ack   = $urandom_range(0, 1);
        mem_rdata = $urandom;
        #1;
        chk("done_stall", stall_out, 0);
        chk("done_req", mem_req, 0);
        chk("done_err", mem_err, to);
        @(negedge clk);
        mem_ack = 1'b0;
        chk("wb_wr", wb_reg_wr, wr & ~to);
        chk("wb_hi", wb_high, hi & ~to);
        chk("wb_lo", wb_low, lo & ~to);
        chk("wb_dst", wb_reg_dst, dst);
        chk("post_err", mem_err, 0);
        if (!to)
            chk("wb_data", wb_data, call ? addr : rdata);
    endtask

    initial begin
        rst_n     = 1'b0;
        mem_ack   = 1'b0;
        mem_rdata = '0;
        drive('0, '0, '0, 0, 0, 0, 0, 0);
        #1;
        chk("rst_req", mem_req, 0);
        chk("rst_we", mem_we, 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_wdata", mem_wdata, 0);
        chk("rst_err", mem_err, 0);
        chk("rst_wb_data", wb_data, 0);
        chk("rst_wb_wr", wb_reg_wr, 0);
        chk("rst_stall", stall_out, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        tbl[0] = '{32'h1234, 4'd5, 1, 0, 0,
                   32'h1234, 4'd5, 1, 0, 0};
        tbl[1] = '{32'hFFFF_FFFF, 4'd15, 1, 1, 1,
                   32'hFFFF_FFFF, 4'd15, 1, 1, 1};
        tbl[2] = '{32'h0, 4'd0, 0, 0, 0,
                   32'h0, 4'd0, 0, 0, 0};
        tbl[3] = '{32'h8000_0001, 4'd9, 0, 1, 0,
                   32'h8000_0001, 4'd9, 0, 1, 0};
        tbl[4] = '{32'h0BAD_F00D, 4'd3, 1, 0, 1,
                   32'h0BAD_F00D, 4'd3, 1, 0, 1};
        for (int i = 0; i < 5; i++) begin
            drive(tbl[i].alu, 32'h0, tbl[i].dst,
                  tbl[i].wr, 0, 0, tbl[i].hi, tbl[i].lo);
            #1;
            chk("tbl_stall", stall_out, 0);
            @(negedge clk);
            chk("tbl_data", wb_data, tbl[i].e_data);
            chk("tbl_dst", wb_reg_dst, tbl[i].e_dst);
            chk("tbl_wr", wb_reg_wr, tbl[i].e_wr);
            chk("tbl_hi", wb_high, tbl[i].e_hi);
            chk("tbl_lo", wb_low, tbl[i].e_lo);
        end

        // load, ack in 2nd BUSY cycle
        mem_op(32'h40, 32'h0, 4'd6, 1, 1, 0, 0, 0,
               2, 32'hDEAD_BEEF, 0);
        // call stores return address
        mem_op(32'h100, 32'h2C, 4'd14, 1, 0, 1, 0, 0,
               1, 32'h5555_5555, 0);
        // load with no ack: timeout
        mem_op(32'h44, 32'h0, 4'd2, 1, 1, 0, 1, 1,
               TO + 1, 32'h0, 0);
        // ack in the last permitted cycle
        mem_op(32'h48, 32'h0, 4'd7, 1, 1, 0, 0, 1,
               TO, 32'hA5A5_0F0F, 0);
        // load+call acts as store
        mem_op(32'h200, 32'h3C, 4'd8, 1, 1, 1, 1, 0,
               3, 32'h1111_2222, 0);
        // stray acks in IDLE ignored
        alu_op(32'h7777, 4'd4, 1, 0, 0, 1);
        mem_op(32'h4C, 32'h0, 4'd1, 1, 1, 0, 0, 0,
               3, 32'h3333_4444, 1);

        // reset in the middle of a BUSY call
        alu_op(32'hCAFE_0001, 4'd7, 1, 1, 1, 0);
        drive(32'h80, 32'h44, 4'd3, 1, 0, 1, 1, 1);
        @(negedge clk);
        chk("pre_rst_req", mem_req, 1);
        chk("pre_rst_we", mem_we, 1);
        @(negedge clk);
        rst_n = 1'b0;
        drive('0, '0, '0, 0, 0, 0, 0, 0);
        #1;
        chk("mid_rst_req", mem_req, 0);
        chk("mid_rst_we", mem_we, 0);
        chk("mid_rst_addr", mem_addr, 0);
        chk("mid_rst_wdata", mem_wdata, 0);
        chk("mid_rst_data", wb_data, 0);
        chk("mid_rst_dst", wb_reg_dst, 0);
        chk("mid_rst_hi", wb_high, 0);
        chk("mid_rst_lo", wb_low, 0);
        chk("mid_rst_err", mem_err, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_err", mem_err, 0);
        chk("post_rst_wr", wb_reg_wr, 0);
        chk("post_rst_req", mem_req, 0);
        @(negedge clk);
        chk("post_rst_err2", mem_err, 0);
        alu_op(32'h1234_5678, 4'd9, 1, 0, 1, 0);

        for (int n = 0; n < 150; n++) begin
            int r;
            r = $urandom_range(0, 9);
            if (r < 5) begin
                alu_op($urandom, 4'($urandom),
                       1'($urandom), 1'($urandom),
                       1'($urandom), 1'($urandom));
            end else begin
                mem_op($urandom, $urandom, 4'($urandom),
                       1'($urandom), r != 8, r >= 8,
                       1'($urandom), 1'($urandom),
                       $urandom_range(1, TO + 3),
                       $urandom, 1'($urandom));
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
